// File: rtl/ysyx_22040237_rf_pkg.sv
// rtl/ysyx_22040237_rf_pkg.sv - shared constants for the scoreboarded register file
//
// Purpose: default geometry of the integer register file, the index of the
// hard-wired zero register and the per-bit reset value of register data.
// Ports: none (package).
package ysyx_22040237_rf_pkg;

  localparam int   RF_XLEN   = 64;
  localparam int   RF_NREG   = 32;
  localparam int   RF_NRD    = 2;
  localparam int   RF_NWR    = 2;

  localparam int   ZERO_REG  = 0;
  localparam logic RESET_BIT = 1'b0;  // every data bit resets to this value

endpackage

// File: rtl/ysyx_22040237_rf_scoreboard.sv
// rtl/ysyx_22040237_rf_scoreboard.sv - busy-bit scoreboard for the integer register file
//
// Purpose: tracks which architectural registers have a result in flight.
// Issue sets a bit, writeback clears it, flush clears all of them.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr       writeback ports (clear sources)
//   alloc_en/alloc_addr issue-time allocation (set source)
//   flush               squash: drop every pending result
//   busy                registered busy bits for registers 1..NREG-1
//   alloc_ok            alloc_addr is free or being released this cycle
//   busy_cnt            registered count of busy registers
module ysyx_22040237_rf_scoreboard
  import ysyx_22040237_rf_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int NWR  = RF_NWR,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*AW-1:0]        wr_addr,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  input  logic                     flush,
  output logic [NREG-1:ZERO_REG+1] busy,
  output logic                     alloc_ok,
  output logic [AW:0]              busy_cnt
);

  // Register 0 has no scoreboard entry at all; it can never be pending.
  logic [NREG-1:ZERO_REG+1] clr;
  logic [NREG-1:ZERO_REG+1] set;
  logic [NREG-1:ZERO_REG+1] busy_next;
  logic [AW:0]              cnt_next;

  always_comb begin
    clr = '0;
    set = '0;
    for (int r = ZERO_REG + 1; r < NREG; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
          clr[r] = 1'b1;
        end
      end
      set[r] = alloc_en && (alloc_addr == AW'(r));
    end
  end

  // Set after clear: a new producer issued in the writeback cycle keeps the
  // register pending. Flush overrides both.
  always_comb begin
    busy_next = flush ? '0 : ((busy & ~clr) | set);
    cnt_next  = '0;
    for (int r = ZERO_REG + 1; r < NREG; r++) begin
      cnt_next = cnt_next + (AW+1)'(busy_next[r]);
    end
  end

  // Addresses 0 and out-of-range addresses have no entry and are always ok.
  always_comb begin
    alloc_ok = 1'b1;
    for (int r = ZERO_REG + 1; r < NREG; r++) begin
      if (alloc_addr == AW'(r)) begin
        alloc_ok = ~busy[r] | clr[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/ysyx_22040237_regfile_sb.sv
// rtl/ysyx_22040237_regfile_sb.sv - multi-port integer register file with busy-bit scoreboard
//
// Purpose: NRD combinational read ports, NWR writeback ports (highest index
// wins on collision), register 0 hard-wired to zero, plus a scoreboard of
// pending results.
// Optional feature macro: YSYX_22040237_RF_BYPASS_EN - same-cycle writeback
// data is forwarded to matching read ports.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_addr/rd_data     read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   rd_busy             per read port: addressed register has a pending result
//   wr_en/wr_addr/wr_data  writeback ports
//   alloc_en/alloc_addr issue-time allocation of a destination register
//   alloc_ok            destination is free (or freed this cycle)
//   flush               clear all busy bits
//   busy_cnt            number of busy registers
module ysyx_22040237_regfile_sb
  import ysyx_22040237_rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = RF_NRD,
  parameter int NWR  = RF_NWR,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic                 alloc_ok,
  input  logic                 flush,
  output logic [AW:0]          busy_cnt
);

  // Register 0 is not stored; address decode below simply never matches it.
  logic [XLEN-1:0]          regs [ZERO_REG+1:NREG-1];
  logic [NREG-1:ZERO_REG+1] busy;

  ysyx_22040237_rf_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy       (busy),
    .alloc_ok   (alloc_ok),
    .busy_cnt   (busy_cnt)
  );

  // Ports are visited in ascending order, so the last (highest-index)
  // matching non-blocking assignment wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = ZERO_REG + 1; r < NREG; r++) begin
        regs[r] <= {XLEN{RESET_BIT}};
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        for (int r = ZERO_REG + 1; r < NREG; r++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
            regs[r] <= wr_data[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Unmatched addresses (0 and >= NREG) fall through to zero / not busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = ZERO_REG + 1; r < NREG; r++) begin
        if (rd_addr[i*AW +: AW] == AW'(r)) begin
          rd_data[i*XLEN +: XLEN] = regs[r];
          rd_busy[i]              = busy[r];
`ifdef YSYX_22040237_RF_BYPASS_EN
          for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
              rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
              rd_busy[i]              = alloc_en && (alloc_addr == AW'(r));
            end
          end
`endif
        end
      end
    end
  end

endmodule

// File: doc/ysyx_22040237_regfile_sb.md
Name: ysyx_22040237_regfile_sb

Overview:
- Parametrised multi-port integer register file with an integrated busy-bit scoreboard, replacing the single-cycle register file for the pipelined core.
- Provides NRD asynchronous read ports and NWR synchronous write (writeback) ports.
- Tracks per-register "result pending" state: set at issue, cleared at writeback, bulk-cleared on pipeline flush.
- Sits between decode/issue (reads, allocations) and the writeback stage.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, $clog2(NREG), register address width (derived, not overridden).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  per read port: the addressed register has a pending result.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- alloc_en  in  1  issue marks alloc_addr as pending.
- alloc_addr  in  AW  destination register being issued.
- alloc_ok  out  1  alloc_addr is free or is being released this cycle (WAW guard).
- flush  in  1  clear all busy bits (pipeline squash).
- busy_cnt  out  AW+1  number of registers currently marked busy.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_cnt 0. Outputs follow combinationally (rd_data 0, rd_busy 0, alloc_ok 1).
- Reads: combinational, zero latency.
  - Address 0 always returns 0 and reports not busy.
  - An address >= NREG returns 0 and reports not busy.
- Writes: take effect at the rising edge.
  - Writes to address 0 or to an address >= NREG are dropped.
  - When several write ports target the same address in one cycle, the highest-index port wins.
- Scoreboard state update (next state):
  - busy_next[r] = (busy[r] & ~clr[r]) | set[r].
  - clr[r] = any wr_en with wr_addr == r.
  - set[r] = alloc_en & alloc_addr == r & r != 0.
  - Allocation and writeback to the same register in one cycle: the register ends busy, because the new producer wins.
  - flush has priority over everything: busy_next = 0 and alloc_en is ignored that cycle. Register data writes still commit during flush.
- alloc_ok = ~busy[alloc_addr] | clr[alloc_addr]. Register 0 is always ok.
  - alloc_en while alloc_ok = 0 is a protocol violation. The bit stays set and no error is flagged.
- busy_cnt is a registered popcount of busy_next, so it is updated on the same edge as the busy bits.
- A write to a register that is not busy is legal; it updates data and leaves busy unchanged.

Optional Feature:
- Macro YSYX_22040237_RF_BYPASS_EN.
- Defined: a read that matches a same-cycle valid write (address nonzero) returns that cycle's wr_data, with the highest-index write port winning. rd_busy for that port is forced 0 unless the same register is also being allocated in that cycle.
- Undefined: reads return stored contents only and rd_busy reflects the registered busy bit. Writeback data becomes visible one cycle later.

Decomposition:
- Package ysyx_22040237_rf_pkg holds:
  - default XLEN/NREG/NRD/NWR constants;
  - the zero-register index constant;
  - the reset data value (all zeros).
- One sub-module, ysyx_22040237_rf_scoreboard, holds:
  - the busy vector, set/clear/flush logic, alloc_ok and busy_cnt.
- The data array, write arbitration and read/bypass muxing stay in the top module.

Test Plan:
- Reset-then-write: rst_n low mid-run, then port0 writes x5=0x1234 -> after the edge rd_addr0=5 gives 0x1234; before reset release all reads are 0.
- x0 protection: wr_en=2'b11 writing x0=0xFFFF and alloc x0 -> rd x0 = 0, rd_busy 0, busy_cnt 0.
- Dual-write collision: port0 x7=0xAA and port1 x7=0xBB in one cycle -> x7 reads 0xBB.
- Scoreboard: alloc x3 -> rd_busy=1, busy_cnt=1, alloc_ok for x3 = 0. A writeback of x3 plus a same-cycle alloc of x3 -> x3 stays busy and busy_cnt stays 1.
- Flush: alloc x1, x2, x4 over three cycles (busy_cnt=3), then flush together with alloc x6 -> busy_cnt=0 and no register busy.
- Bypass: with the macro defined, write x9=0x55 while reading x9 in the same cycle -> rd_data=0x55, rd_busy=0. With the macro undefined -> old value in that cycle, 0x55 on the next cycle.
